// File: rtl/pulse_receiver.sv
// ---------------------------------------------------------------------------
// pulse_receiver
//
// Receives a stretched event pulse from a remote board on an asynchronous
// line. The line is synchronized into the clk domain. An event is accepted
// once it has been high for MIN_HIGH consecutive synchronized samples. A line
// that stays high for MAX_HIGH samples is reported as stuck with a sticky
// flag.
//
// Parameters:
//   MIN_HIGH    consecutive high samples needed to accept an event (default 4)
//   MAX_HIGH    consecutive high samples that declare the line stuck (default 12)
//               legal range: 2 <= MIN_HIGH < MAX_HIGH <= 15
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   line_in      in   asynchronous event line
//   pulse_out    out  one-cycle strobe per accepted event (registered)
//   busy         out  high while the FSM is not in IDLE
//   err_stuck    out  sticky stuck-line flag, cleared only by rst
//   event_count  out  accepted events, modulo 256
// ---------------------------------------------------------------------------
module pulse_receiver #(
    parameter int MIN_HIGH = 4,
    parameter int MAX_HIGH = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    output logic       pulse_out,
    output logic       busy,
    output logic       err_stuck,
    output logic [7:0] event_count
);

    // Elaboration-time guard on the parameter range.
    generate
        if (MIN_HIGH < 2 || MIN_HIGH >= MAX_HIGH || MAX_HIGH > 15) begin : g_bad_params
            $error("pulse_receiver: require 2 <= MIN_HIGH < MAX_HIGH <= 15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        WAIT_LOW = 2'd2,
        STUCK    = 2'd3
    } state_t;

    localparam logic [3:0] MIN_LAST = 4'(MIN_HIGH - 1);
    localparam logic [3:0] MAX_LAST = 4'(MAX_HIGH - 1);

    state_t     state;
    logic       s1;
    logic       s2;
    logic       line_s;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;

    assign line_s  = s2;
    // High-sample counter saturates at 15 so a line held high forever
    // cannot wrap back into the acceptance window.
    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign busy    = (state != IDLE);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values; s2 <= s1 then forms a true
    // two-flop synchronizer instead of collapsing into one stage.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and checked first, so it overrides the
        // line in the same cycle and also flushes the synchronizer; a line
        // still high after release is therefore seen as a fresh event.
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE;
            cnt         <= 4'd0;
            pulse_out   <= 1'b0;
            err_stuck   <= 1'b0;
            event_count <= 8'd0;
        end else begin
            s1        <= line_in;
            s2        <= s1;
            // Strobe defaults low; only the MEASURE acceptance branch raises it.
            pulse_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (line_s) begin
                        state <= MEASURE;
                        cnt   <= 4'd1;
                    end else begin
                        cnt <= 4'd0;
                    end
                end

                MEASURE: begin
                    if (!line_s) begin
                        // Too short: glitch rejected, nothing counted.
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == MIN_LAST) begin
                        cnt         <= cnt_inc;
                        pulse_out   <= 1'b1;
                        event_count <= event_count + 8'd1;
                        state       <= WAIT_LOW;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                WAIT_LOW: begin
                    // Event already accepted; wait for the line to drop so one
                    // high period never yields a second strobe.
                    if (!line_s) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt >= MAX_LAST) begin
                        state     <= STUCK;
                        err_stuck <= 1'b1;
                        cnt       <= cnt_inc;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                STUCK: begin
                    // err_stuck is left untouched here: it is sticky until rst.
                    if (!line_s) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_receiver.sv
// ---------------------------------------------------------------------------
// tb_pulse_receiver
//
// Self-checking bench for pulse_receiver. Every cycle the DUT outputs are
// compared against a run-length reference model: the model delays line_in by
// two samples, counts the length of the current high run, and derives the
// strobe, stuck flag, busy and event count directly from that run length.
// A short table of hand-derived vectors covers the basic latency case; hand
// sequences cover glitches, stuck lines, back-to-back events, counter wrap and
// reset mid-event; a randomized phase closes out the run.
// ---------------------------------------------------------------------------
module tb_pulse_receiver;

    localparam int MIN_HIGH = 4;
    localparam int MAX_HIGH = 12;

    logic       clk;
    logic       rst;
    logic       line_in;
    logic       pulse_out;
    logic       busy;
    logic       err_stuck;
    logic [7:0] event_count;

    pulse_receiver #(
        .MIN_HIGH(MIN_HIGH),
        .MAX_HIGH(MAX_HIGH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .err_stuck  (err_stuck),
        .event_count(event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    // Reference model state.
    logic m_d1, m_d2;     // two-sample delay of line_in
    int   m_run;          // length of the current high run seen after the delay
    logic m_pulse;
    logic m_err;
    int   m_count;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic l);
        logic seen;
        if (r) begin
            m_d1 = 0; m_d2 = 0; m_run = 0;
            m_pulse = 0; m_err = 0; m_count = 0;
        end else begin
            seen  = m_d2;
            m_d2  = m_d1;
            m_d1  = l;
            if (seen) begin
                m_run++;
                m_pulse = (m_run == MIN_HIGH);
                if (m_pulse) m_count = (m_count + 1) % 256;
                if (m_run == MAX_HIGH) m_err = 1;
            end else begin
                m_run   = 0;
                m_pulse = 0;
            end
        end
    endtask

    // One clock: drive at negedge, update model at posedge, sample 1 time
    // unit after the edge and compare every output against the model.
    task automatic apply(input logic r, input logic l);
        @(negedge clk);
        rst     = r;
        line_in = l;
        @(posedge clk);
        model_step(r, l);
        #1;
        if (pulse_out === 1'b1) strobes++;
        check("pulse_out",   int'(pulse_out),   int'(m_pulse));
        check("busy",        int'(busy),        int'(m_run > 0));
        check("err_stuck",   int'(err_stuck),   int'(m_err));
        check("event_count", int'(event_count), m_count);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        strobes = 0;
    endtask

    typedef struct {
        logic       line;
        logic       pulse;
        logic       busy;
        logic       err;
        logic [7:0] count;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic level;
        int   rem;
        logic r;

        rst     = 1'b1;
        line_in = 1'b0;

        // 8-cycle pulse starting at E0: strobe only after E5, busy E2..E9.
        for (int i = 0; i < 14; i++) begin
            tbl[i].line  = (i < 8);
            tbl[i].pulse = (i == 5);
            tbl[i].busy  = (i >= 2 && i <= 9);
            tbl[i].err   = 1'b0;
            tbl[i].count = (i >= 5) ? 8'd1 : 8'd0;
        end

        // Reset state.
        do_reset();
        check("rst pulse_out",   int'(pulse_out),   0);
        check("rst busy",        int'(busy),        0);
        check("rst err_stuck",   int'(err_stuck),   0);
        check("rst event_count", int'(event_count), 0);

        // Table: nominal 8-cycle event.
        for (int i = 0; i < 14; i++) begin
            apply(1'b0, tbl[i].line);
            check("tbl pulse_out",   int'(pulse_out),   int'(tbl[i].pulse));
            check("tbl busy",        int'(busy),        int'(tbl[i].busy));
            check("tbl err_stuck",   int'(err_stuck),   int'(tbl[i].err));
            check("tbl event_count", int'(event_count), int'(tbl[i].count));
        end
        check("tbl strobes", strobes, 1);

        // 3-cycle glitch: rejected, FSM idle again at E5.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, i < 3);
            if (i == 4) check("glitch busy E4", int'(busy), 1);
            if (i == 5) check("glitch busy E5", int'(busy), 0);
        end
        check("glitch strobes", strobes, 0);
        check("glitch count", int'(event_count), 0);

        // Line held 20 cycles: one strobe, stuck flag from E13, stays sticky.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1);
            if (i == 5)  check("stuck strobe E5", int'(pulse_out), 1);
            if (i == 12) check("stuck err E12", int'(err_stuck), 0);
            if (i == 13) check("stuck err E13", int'(err_stuck), 1);
        end
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b0);
        check("stuck err sticky", int'(err_stuck), 1);
        check("stuck busy after fall", int'(busy), 0);
        for (int i = 0; i < 12; i++) apply(1'b0, i < 8);
        check("stuck then event count", int'(event_count), 2);
        check("stuck then event strobes", strobes, 2);
        check("stuck err after event", int'(err_stuck), 1);

        // Two 8-cycle pulses separated by a single low cycle.
        do_reset();
        for (int i = 0; i < 8; i++) apply(1'b0, 1'b1);
        apply(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0);
        check("b2b strobes", strobes, 2);
        check("b2b count", int'(event_count), 2);

        // 256 events: counter wraps to 0.
        do_reset();
        for (int e = 0; e < 256; e++) begin
            for (int i = 0; i < 8; i++) apply(1'b0, 1'b1);
            for (int i = 0; i < 2; i++) apply(1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0);
        check("wrap strobes", strobes, 256);
        check("wrap count", int'(event_count), 0);
        check("wrap err", int'(err_stuck), 0);

        // Reset at E4 during an 8-cycle pulse.
        do_reset();
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1);
        apply(1'b1, 1'b1);
        check("midrst strobes before", strobes, 0);
        check("midrst busy", int'(busy), 0);
        check("midrst count", int'(event_count), 0);
        check("midrst err", int'(err_stuck), 0);
        for (int i = 5; i < 8; i++) apply(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) apply(1'b0, 1'b0);
        check("midrst strobes at most one", int'(strobes <= 1), 1);

        // Randomized runs of high/low with occasional reset.
        do_reset();
        level = 1'b0;
        rem   = 3;
        for (int c = 0; c < 4000; c++) begin
            if (rem == 0) begin
                level = ~level;
                rem   = level ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 4));
            end
            r = ($urandom_range(0, 299) == 0);
            apply(r, level);
            rem--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
